// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential RISC-V M-extension unit.
package mdu_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  // rs1 is treated as a signed value by these ops
  function automatic logic op_signed_a(op_e o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  // rs2 is treated as a signed value by these ops
  function automatic logic op_signed_b(op_e o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negation, used for operand magnitudes at
// accept time and for the final sign correction of product/quotient/remainder.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  logic signed [W-1:0] a_s;

  assign a_s = a;
  assign y   = neg ? -a_s : a_s;

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit (RISC-V M extension) that borrows a shared
// ALU for its 32 iteration steps. Division is compiled in only when the
// macro MDU_DIV_EN is defined; otherwise divide ops complete immediately
// with a zero result.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_comp,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_sel,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITER_CNT);

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  // acc: product high word / partial remainder
  // lo : product low word (multiplier) / dividend shifting into quotient
  // opb: multiplicand / divisor
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;
  logic             neg_q;

  op_e              op_in;
  logic             sa;
  logic             sb;
  logic [XLEN-1:0]  abs1;
  logic [XLEN-1:0]  abs2;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]  fix_res;
  logic [XLEN-1:0]  acc_nxt;
  logic [XLEN-1:0]  lo_nxt;
  logic             carry;

  assign op_in = op_e'(op);
  assign sa    = op_signed_a(op_in) & rs1[XLEN-1];
  assign sb    = op_signed_b(op_in) & rs2[XLEN-1];

  mdu_signfix #(.W(XLEN)) u_abs1 (.a(rs1), .neg(sa), .y(abs1));
  mdu_signfix #(.W(XLEN)) u_abs2 (.a(rs2), .neg(sb), .y(abs2));
  mdu_signfix #(.W(2*XLEN)) u_prod (.a({acc, lo}), .neg(neg_q), .y(prod_fix));

`ifdef MDU_DIV_EN
  logic            neg_r;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  mdu_signfix #(.W(XLEN)) u_quo (.a(lo), .neg(neg_q), .y(quo_fix));
  mdu_signfix #(.W(XLEN)) u_rem (.a(acc), .neg(neg_r), .y(rem_fix));
`else
  logic unused_alu_comp;
  assign unused_alu_comp = alu_comp;
`endif

  // the add wrapped around exactly when the sum is below an addend
  assign carry = (alu_res < acc);

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign stall = (!reset && (state == S_IDLE) && start && !kill) ||
                 (state == S_ITER) || (state == S_FIX);

  // shared ALU request: operands only while iterating, zero otherwise
  always_comb begin
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 3'b000;
    if (state == S_ITER) begin
      alu_req = 1'b1;
      alu_a   = acc;
      alu_b   = opb;
`ifdef MDU_DIV_EN
      if (op_q[2]) begin
        alu_sel = 3'b001;
        alu_a   = {acc[XLEN-2:0], lo[XLEN-1]};
      end
`endif
    end
  end

  // one shift-add (multiply) or shift-subtract (divide) step
  always_comb begin
    acc_nxt = {1'b0, acc[XLEN-1:1]};
    lo_nxt  = {acc[0], lo[XLEN-1:1]};
    if (lo[0]) begin
      acc_nxt = {carry, alu_res[XLEN-1:1]};
      lo_nxt  = {alu_res[0], lo[XLEN-1:1]};
    end
`ifdef MDU_DIV_EN
    if (op_q[2]) begin
      // a bit shifted out of the remainder means it already exceeds the divisor
      if (acc[XLEN-1] || !alu_comp) begin
        acc_nxt = alu_res;
        lo_nxt  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[XLEN-2:0], lo[XLEN-1]};
        lo_nxt  = {lo[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  // select the architectural result word after sign correction
  always_comb begin
    fix_res = prod_fix[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:          fix_res = prod_fix[XLEN-1:0];
`ifdef MDU_DIV_EN
      OP_DIV, OP_DIVU: fix_res = quo_fix;
      OP_REM, OP_REMU: fix_res = rem_fix;
`endif
      default:         fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      acc    <= '0;
      lo     <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
`ifdef MDU_DIV_EN
      neg_r  <= 1'b0;
`endif
      result <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            cnt   <= '0;
            acc   <= '0;
            neg_q <= sa ^ sb;
            if (op[2]) begin
`ifdef MDU_DIV_EN
              neg_r <= sa;
              if (rs2 == '0) begin
                state  <= S_DONE;
                result <= op[1] ? rs1 : '1;
              end else begin
                state <= S_ITER;
                lo    <= abs1;
                opb   <= abs2;
              end
`else
              state  <= S_DONE;
              result <= '0;
`endif
            end else begin
              state <= S_ITER;
              lo    <= abs2;
              opb   <= abs1;
            end
          end
        end
        S_ITER: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER_CNT - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with a behavioural shared ALU.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic [31:0] alu_res;
  logic        alu_comp;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .kill     (kill),
    .alu_res  (alu_res),
    .alu_comp (alu_comp),
    .alu_req  (alu_req),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // shared ALU: 000 add, 001 subtract; comp is unsigned a<b
  assign alu_res  = (alu_sel == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_comp = (alu_a < alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one op, wait for done, check latency (edges from accept edge = 1),
  // result, whether the ALU was borrowed, and that the result holds afterwards
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   n;
    logic seen_req;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    #1 check({tag, " stall"}, stall, 1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    seen_req = alu_req;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      seen_req = seen_req | alu_req;
    end
    check({tag, " lat"}, n, exp_lat);
    check({tag, " res"}, result, exp_res);
    check({tag, " req"}, seen_req, (exp_lat > 1) ? 1 : 0);
    @(posedge clk);
    #1 check({tag, " hold"}, {busy, done, result}, {2'b00, exp_res});
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (done) cnt++;
    end
  endtask

  initial begin
    int n;
    int dcnt;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1 check("reset outs", {busy, stall, done, alu_req, alu_a, alu_b, alu_sel, result}, 0);
    @(negedge clk);
    reset = 1'b0;

    // multiply
    run_op("mulhu ff*ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mul ff*ff",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run_op("mulh -2*3",   3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34);
    run_op("mulhsu -1*2", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    run_op("mul 7*-3",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu 2^16sq",3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34);
    run_op("mulh min*min",3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);

`ifdef MDU_DIV_EN
    run_op("div -7/2",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
    run_op("divu 2^31/3", 3'b101, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, 34);
    run_op("remu 2^31/3", 3'b111, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 34);
    run_op("remu big",    3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
    run_op("divu 5/0",    3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op("rem 9/0",     3'b110, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1);
    run_op("div ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run_op("rem ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
`else
    run_op("divu 10/3",   3'b101, 32'h0000_000A, 32'h0000_0003, 32'h0000_0000, 1);
    run_op("rem 9/0",     3'b110, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1);
    run_op("div -7/2",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 1);
`endif

    // set a known result before the abort scenarios
    run_op("mul 2*3",     3'b000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 34);

    // kill in the 10th ITER cycle
    @(negedge clk);
    op = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("iter busy", {busy, stall, alu_req}, 3'b111);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 check("kill outs", {busy, stall, done, alu_req, result}, {4'b0000, 32'h0000_0006});
    kill = 1'b0;
    count_done(40, dcnt);
    check("kill no done", dcnt, 0);

    // start while busy is ignored
    @(negedge clk);
    op = 3'b000; rs1 = 32'h0000_0004; rs2 = 32'h0000_0005; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    repeat (4) @(posedge clk);
    n += 4;
    @(negedge clk);
    op = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n++;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("busy start lat", n, 34);
    check("busy start res", result, 32'h0000_0014);
    count_done(40, dcnt);
    check("busy start 1 done", dcnt, 0);

    // kill together with start in IDLE rejects the start
    @(negedge clk);
    op = 3'b000; rs1 = 32'h0000_0003; rs2 = 32'h0000_0003; start = 1'b1; kill = 1'b1;
    #1 check("kill start stall", stall, 0);
    @(posedge clk);
    #1 check("kill start busy", busy, 0);
    start = 1'b0; kill = 1'b0;

    // reset in the middle of ITER
    @(negedge clk);
    op = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("mid reset outs", {busy, stall, done, alu_req, alu_a, alu_b, alu_sel, result}, 0);
    @(negedge clk);
    reset = 1'b0;
    count_done(40, dcnt);
    check("mid reset no done", dcnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new M-extension operation.
REQ-005 SHALL have port op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports rs1, rs2  input  32  operands, sampled only when start is accepted.
REQ-007 SHALL have port kill  input  1  pipeline flush; aborts any operation.
REQ-008 SHALL have ports alu_res  input  32 and alu_comp  input  1  result and unsigned a<b flag returned by the shared ALU.
REQ-009 SHALL have ports alu_req  output  1, alu_a  output  32, alu_b  output  32, alu_sel  output  3  borrow-request and operands for the shared ALU.
REQ-010 SHALL have ports busy, stall, done  output  1 each, and result  output  32.

Function
REQ-011 States SHALL be IDLE, ITER, FIX, DONE; busy = (state != IDLE).
REQ-012 In IDLE, start=1 with kill=0 SHALL be accepted: operands and op latched, iteration count 0, next state ITER (FIX never skipped).
REQ-013 start while not in IDLE SHALL be ignored.
REQ-014 ITER SHALL last exactly 32 cycles, then FIX for 1 cycle, then DONE for 1 cycle, then IDLE; done=1 only in DONE (34 cycles after the accepting edge).
REQ-015 stall SHALL be 1 when (IDLE and start and !kill) or state is ITER or FIX; 0 otherwise.
REQ-016 alu_req SHALL be 1 only in ITER; otherwise alu_a=0, alu_b=0, alu_sel=000.
REQ-017 Signed ops SHALL convert operands to magnitudes at accept using local negation; the shared ALU is used only for iteration steps.
REQ-018 Multiply step: if product_lo[0], alu_sel=000, alu_a=product_hi, alu_b=multiplicand; carry=(alu_res < product_hi); {carry,sum,lo} shifted right by 1; else plain shift.
REQ-019 Divide step: rem shifted left with next dividend MSB; alu_sel=001, alu_a=rem, alu_b=divisor; subtract when shifted-out bit=1 or alu_comp=0 (quotient bit 1), else keep rem (bit 0).
REQ-020 FIX SHALL apply sign correction (product negated if signs differ; quotient sign = xor, remainder sign = dividend) and select the low/high/quotient/remainder word.
REQ-021 result SHALL hold its value from DONE until the next DONE; reset value 0.
REQ-022 Divide by zero SHALL bypass ITER/FIX (IDLE->DONE next cycle): DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL produce 0x80000000; REM produces 0.
REQ-024 kill=1 in any state SHALL force IDLE next cycle with done=0 and result unchanged; kill with start in IDLE SHALL reject start.

Reset
REQ-025 On reset: state IDLE, busy=0, stall=0, done=0, alu_req=0, alu_a=0, alu_b=0, alu_sel=000, result=0, internal registers 0; reset overrides start and kill.
REQ-026 Reset mid-operation SHALL abandon it with no done pulse.

Configuration
REQ-027 Macro MDU_DIV_EN SHALL compile in division; defined: REQ-019/022/023 apply.
REQ-028 Without MDU_DIV_EN, ops 100-111 SHALL go IDLE->DONE next cycle with result 0 and no alu_req; divide datapath absent.

Structure
REQ-029 Package mdu_pkg SHALL hold the op enum, state enum, XLEN and ITER_CNT (32) constants.
REQ-030 Sub-module mdu_signfix SHALL implement conditional 32/64-bit negation used at accept and in FIX.

Verification
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34, result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-032 MULH 0xFFFFFFFE (-2) x 3 -> result 0xFFFFFFFF; MULHSU -1 x 2 -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x80000000/3 -> 0x2AAAAAAA.
REQ-034 DIVU 5/0 -> done 1 cycle after accept, result 0xFFFFFFFF, alu_req never 1; DIV 0x80000000/-1 -> 0x80000000.
REQ-035 kill at ITER cycle 10 -> IDLE next cycle, no done, result unchanged; start during busy ignored (no second done).
REQ-036 Reset asserted during ITER -> all outputs at reset values next cycle; build without MDU_DIV_EN: DIVU 10/3 -> result 0 after 1 cycle.
